// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch-stage constants, fault codes and state encoding.
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE = 2'd2;
  typedef enum logic {ST_RUN, ST_FAULT} fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory, redirect and decode-handshake signals of the fetch stage.
interface instr_fetch_if;
  import rv32i_pkg::*;
  logic [XLEN-1:0] instr_addr, instr, redirect_pc, id_instr, id_pc, id_pc_plus4, fetch_count;
  logic            redirect_valid, id_ready, id_valid;
  logic [1:0]      id_fault;
  modport master (
    output instr_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_fault, fetch_count,
    input  instr, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  instr_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_fault, fetch_count,
    output instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; kill beats load, load beats clear, otherwise hold.
module if_id_reg
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            kill_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      fault_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [1:0]      fault_o
);
  logic            valid_q, valid_d, wr;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
  logic [1:0]      fault_q, fault_d;
  always_comb begin
    wr      = load_i & ~kill_i;
    valid_d = kill_i ? 1'b0 : load_i ? 1'b1 : clr_i ? 1'b0 : valid_q;
    instr_d = wr ? instr_i : instr_q;
    pc_d    = wr ? pc_i : pc_q;
    pc4_d   = wr ? pc_i + 32'd4 : pc4_q;
    fault_d = wr ? fault_i : fault_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      fault_q <= fault_d;
    end
  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign fault_o    = fault_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, fetch-fault detection and IF/ID handoff to decode.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 512
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, count_q, count_d;
  logic [1:0]      fault_now;
  logic            accept, advance;
  always_comb begin
    accept    = bus.id_valid & bus.id_ready;
    advance   = (state_q == ST_RUN) & (~bus.id_valid | bus.id_ready);
    fault_now = (pc_q[1:0] != 2'b00) ? FAULT_MISALIGN :
                ({2'b00, pc_q[31:2]} >= IMEM_WORDS) ? FAULT_RANGE : FAULT_NONE;
    state_d   = bus.redirect_valid ? ST_RUN :
                (advance && fault_now != FAULT_NONE) ? ST_FAULT : state_q;
    pc_d      = bus.redirect_valid ? bus.redirect_pc :
                (advance && fault_now == FAULT_NONE) ? pc_q + 32'd4 : pc_q;
    count_d   = accept ? count_q + 32'd1 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  // A faulting fetch hands decode a NOP so the fault code travels as the only side effect.
  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (advance),
    .kill_i     (bus.redirect_valid),
    .clr_i      (accept),
    .instr_i    ((fault_now != FAULT_NONE) ? NOP_INSTR : bus.instr),
    .pc_i       (pc_q),
    .fault_i    (fault_now),
    .valid_o    (bus.id_valid),
    .instr_o    (bus.id_instr),
    .pc_o       (bus.id_pc),
    .pc_plus4_o (bus.id_pc_plus4),
    .fault_o    (bus.id_fault)
  );
  assign bus.instr_addr  = pc_q;
  assign bus.fetch_count = count_q;
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC-generation and fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives instr_addr; the memory returns instr combinationally in the same cycle.
- Captures instr into an IF/ID pipeline register, which feeds decode through a valid/ready handshake.
- Handles redirects (branch/jump/trap), stalls, and fetch faults for misaligned or out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 512, instruction-memory depth in words; any PC with pc[31:2] >= IMEM_WORDS is out of range.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_addr  out  32  byte address to instruction memory; always equal to pc_q.
- instr  in  32  instruction word from memory, valid in the same cycle.
- redirect_valid  in  1  load a new PC and kill the IF/ID contents.
- redirect_pc  in  32  redirect target (byte address).
- id_ready  in  1  decode accepts the IF/ID entry this cycle.
- id_valid  out  1  IF/ID entry valid.
- id_instr  out  32  fetched instruction, or NOP 32'h0000_0013 when faulted.
- id_pc  out  32  PC of the entry.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- id_fault  out  2  0 = none, 1 = misaligned PC, 2 = PC out of range.
- fetch_count  out  32  number of entries accepted by decode; wraps at 2^32.

Behaviour:
- Reset (async assert, sync release):
  - pc_q = RESET_PC; state = RUN.
  - id_valid = 0, id_instr = 32'h0000_0013, id_pc = 0, id_pc_plus4 = 0, id_fault = 0.
  - fetch_count = 0.
  - Reset asserted mid-stall or in FAULT discards everything immediately.
- instr_addr = pc_q combinationally; no registered read. Fetch latency is 1 cycle: address out in cycle N, entry valid in cycle N+1.
- Derived terms:
  - accept = id_valid & id_ready.
  - advance = (state == RUN) & (!id_valid | id_ready).
  - fault_now = (pc_q[1:0] != 0) ? 1 : (pc_q[31:2] >= IMEM_WORDS) ? 2 : 0. Misaligned takes priority.
- States: RUN and FAULT.
  - RUN: fetching.
  - FAULT: a faulting entry has been issued; fetch stops and pc_q holds.
- Per-cycle priority, highest first:
  1. redirect_valid:
     - pc_q <= redirect_pc; id_valid <= 0; state <= RUN.
     - fetch_count still increments if accept is true this same cycle.
     - A misaligned redirect_pc is not checked here; it faults on the next fetch.
  2. advance with fault_now != 0:
     - id_valid <= 1; id_instr <= NOP; id_pc <= pc_q; id_pc_plus4 <= pc_q + 4; id_fault <= fault_now.
     - pc_q holds; state <= FAULT.
  3. advance with no fault:
     - id_valid <= 1; id_instr <= instr; id_pc <= pc_q; id_pc_plus4 <= pc_q + 4; id_fault <= 0.
     - pc_q <= pc_q + 4.
  4. else if accept (only possible in FAULT): id_valid <= 0.
  5. else: hold all IF/ID registers and pc_q.
- Stall: while id_valid & !id_ready, id_* are stable and pc_q is stable.
- FAULT is left only by redirect_valid. id_ready has no effect there except consuming the held entry.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 0; 0 is then checked against IMEM_WORDS.
- fetch_count increments on each accept, including faulted entries.
- No combinational path from id_ready or redirect_valid to any output except through registers.

Decomposition:
- Shared package rv32i_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - Fault code localparams FAULT_NONE/MISALIGN/RANGE (2 bits).
  - The fetch state encoding.
  - XLEN = 32.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/kill/hold controls.
- PC/next-PC logic and the FSM stay in instr_fetch.

Test Plan:
- Reset then id_ready = 1 steady, memory words 0..3 = A0..A3:
  - instr_addr sequence is 0, 4, 8, 12.
  - id_valid rises 1 cycle after reset release.
  - id_instr = A0, A1, A2 with id_pc = 0, 4, 8; fetch_count = 3 after 3 accepts.
- Stall: id_ready = 0 for 3 cycles while the id_pc = 8 entry is valid:
  - id_* and instr_addr = 12 hold.
  - After release, next entry has id_pc = 12; no entry skipped or duplicated.
- Redirect with redirect_pc = 0x40 while id_valid = 1 and id_ready = 0:
  - Next cycle id_valid = 0 and instr_addr = 0x40.
  - Following entry has id_pc = 0x40, id_pc_plus4 = 0x44.
- Redirect to 0x42:
  - Entry id_pc = 0x42, id_fault = 1, id_instr = 0x00000013.
  - instr_addr stays 0x42 for 5 cycles with no new entries.
  - A redirect to 0x10 resumes fetch.
- Redirect to 0x800 (word 512, IMEM_WORDS = 512): entry with id_fault = 2, id_pc = 0x800; fetch stops.
- Assert rst_n low mid-stall (fetch_count = 7): outputs immediately return to reset values, and instr_addr = RESET_PC.
